// File: rtl/div_sched_pkg.sv
// Shared types, constants and the round-robin pick function for the divider scheduler.
package div_sched_pkg;

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    // Upper bound on requesters handled by rr_pick; callers zero-pad their valid vector.
    localparam int MAX_REQ = 32;

    // Truncated to WIDTH at the use site, so WIDTH may not exceed 64.
    localparam logic [63:0] DBZ_QUOTIENT = '1;

    // First asserted valid scanning last+1, last+2, ... modulo n.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                            input int unsigned last,
                                            input int unsigned n);
        int unsigned idx;
        logic found;
        rr_pick = last;
        found   = 1'b0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            idx = 0;
            if (i <= n) begin
                idx = last + i;
                if (idx >= n) idx = idx - n;
                if (!found && valid[idx]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/div_core.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, WIDTH cycles per divide.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);

    logic             active;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] qsh;   // dividend bits shift out the top, quotient bits shift in below
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] q_nxt;

    always_comb begin
        partial = {rem, qsh[WIDTH-1]};
        ge      = partial >= {1'b0, dvs};
        diff    = partial - {1'b0, dvs};
        rem_nxt = ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
        q_nxt   = {qsh[WIDTH-2:0], ge};
    end

    // done marks the cycle whose edge completes the last bit; quotient/remainder are
    // the post-edge values so the caller can register them on that same edge.
    assign done      = active && (cnt == CW'(WIDTH - 1));
    assign quotient  = q_nxt;
    assign remainder = rem_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
            rem    <= '0;
            qsh    <= '0;
            dvs    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            rem    <= '0;
            qsh    <= dividend;
            dvs    <= divisor;
        end else if (active) begin
            rem <= rem_nxt;
            qsh <= q_nxt;
            cnt <= cnt + 1'b1;
            if (done) active <= 1'b0;
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// Round-robin arbiter sharing one restoring divider among NREQ requesters, with a
// tagged single response stream and immediate divide-by-zero answers.
module div_scheduler
    import div_sched_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 32,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_quotient,
    output logic [WIDTH-1:0]      rsp_remainder,
    output logic                  rsp_div_by_zero,
    output logic                  busy
);
    state_t           state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   cur_id;
    logic [IDW-1:0]   grant;
    logic             any_valid;
    logic             accept;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;
    logic             core_start;
    logic             core_done;
    logic [WIDTH-1:0] core_q;
    logic [WIDTH-1:0] core_r;

    always_comb begin
        grant        = IDW'(rr_pick(MAX_REQ'(req_valid), 32'(last_grant), NREQ));
        any_valid    = |req_valid;
        accept       = (state == IDLE) && any_valid;
        sel_dividend = req_dividend[grant*WIDTH +: WIDTH];
        sel_divisor  = req_divisor[grant*WIDTH +: WIDTH];
        core_start   = accept && (sel_divisor != '0);
        // Gated by rst_n so every output reads zero while reset is held.
        req_ready    = '0;
        if (rst_n && accept) req_ready[grant] = 1'b1;
    end

    assign busy = (state != IDLE);

    div_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (core_start),
        .dividend (sel_dividend),
        .divisor  (sel_divisor),
        .done     (core_done),
        .quotient (core_q),
        .remainder(core_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            last_grant      <= IDW'(NREQ - 1);
            cur_id          <= '0;
            rsp_valid       <= 1'b0;
            rsp_id          <= '0;
            rsp_quotient    <= '0;
            rsp_remainder   <= '0;
            rsp_div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    last_grant <= grant;
                    cur_id     <= grant;
                    if (sel_divisor == '0) begin
                        state           <= RESP;
                        rsp_valid       <= 1'b1;
                        rsp_id          <= grant;
                        rsp_quotient    <= WIDTH'(DBZ_QUOTIENT);
                        rsp_remainder   <= sel_dividend;
                        rsp_div_by_zero <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: if (core_done) begin
                    state           <= RESP;
                    rsp_valid       <= 1'b1;
                    rsp_id          <= cur_id;
                    rsp_quotient    <= core_q;
                    rsp_remainder   <= core_r;
                    rsp_div_by_zero <= 1'b0;
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler: latency, arithmetic, round-robin order, backpressure, reset.
module tb_div_scheduler;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_dividend;
    logic [NREQ*WIDTH-1:0] req_divisor;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_quotient;
    logic [WIDTH-1:0]      rsp_remainder;
    logic                  rsp_div_by_zero;
    logic                  busy;

    int n_cmp = 0;
    int n_err = 0;

    div_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_quotient   (rsp_quotient),
        .rsp_remainder  (rsp_remainder),
        .rsp_div_by_zero(rsp_div_by_zero),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_dividend[i*WIDTH +: WIDTH] = a;
        req_divisor[i*WIDTH +: WIDTH]  = b;
    endtask

    // Starts and ends just after a negedge; returns edges from accept until rsp_valid.
    task automatic run_one(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           output int lat);
        int w;
        logic [NREQ-1:0] exp_rdy;
        exp_rdy   = '0;
        exp_rdy[id] = 1'b1;
        set_op(id, a, b);
        req_valid = exp_rdy;
        #1;
        w = 0;
        while (req_ready !== exp_rdy && w < 50) begin
            @(negedge clk); #1;
            w++;
        end
        chk("grant_ready", 64'(req_ready), 64'(exp_rdy));
        @(negedge clk);
        req_valid = '0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int w;
        int ng;
        int viol;
        int g;
        int grants[5];
        logic [NREQ-1:0] prev;
        int bp_bad;

        rst_n        = 1'b0;
        req_valid    = 4'hF;
        rsp_ready    = 1'b0;
        req_dividend = '0;
        req_divisor  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_fields", {rsp_quotient, rsp_remainder}, 0);
        chk("rst_id_dbz", {rsp_id, rsp_div_by_zero}, 0);
        req_valid = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);

        // Basic division, first grant goes to requester 0
        run_one(0, 100, 7, lat);
        chk("basic_lat", lat, 33);
        chk("basic_id", 64'(rsp_id), 0);
        chk("basic_q", 64'(rsp_quotient), 14);
        chk("basic_r", 64'(rsp_remainder), 2);
        chk("basic_dbz", 64'(rsp_div_by_zero), 0);
        @(negedge clk);
        chk("basic_drop_valid", 64'(rsp_valid), 0);
        chk("basic_idle", 64'(busy), 0);

        // Divide by zero answers one edge after accept
        run_one(1, 32'h1234, 0, lat);
        chk("dbz_lat", lat, 1);
        chk("dbz_id", 64'(rsp_id), 1);
        chk("dbz_q", 64'(rsp_quotient), 64'h0000_0000_FFFF_FFFF);
        chk("dbz_r", 64'(rsp_remainder), 64'h1234);
        chk("dbz_flag", 64'(rsp_div_by_zero), 1);
        @(negedge clk);

        // Large divisor
        run_one(2, 32'hFFFF_FFFF, 32'h8000_0001, lat);
        chk("large_lat", lat, 33);
        chk("large_id", 64'(rsp_id), 2);
        chk("large_q", 64'(rsp_quotient), 1);
        chk("large_r", 64'(rsp_remainder), 64'h7FFF_FFFE);
        @(negedge clk);

        // Dividend smaller than divisor
        run_one(3, 5, 9, lat);
        chk("small_id", 64'(rsp_id), 3);
        chk("small_q", 64'(rsp_quotient), 0);
        chk("small_r", 64'(rsp_remainder), 5);
        chk("small_dbz", 64'(rsp_div_by_zero), 0);
        @(negedge clk);

        // Fairness: all requesters held valid, last grant was 3
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(1000 + i), 3);
        req_valid = 4'hF;
        ng   = 0;
        viol = 0;
        prev = '0;
        for (int c = 0; c < 400 && ng < 5; c++) begin
            #1;
            if (req_ready != '0) begin
                if ($countones(req_ready) != 1 || busy || prev != '0) viol++;
                g = 0;
                for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
                grants[ng] = g;
                ng++;
            end else if (!busy) begin
                viol++;
            end
            prev = req_ready;
            @(negedge clk);
        end
        req_valid = '0;
        w = 0;
        while (busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("fair_count", ng, 5);
        chk("fair_g0", grants[0], 0);
        chk("fair_g1", grants[1], 1);
        chk("fair_g2", grants[2], 2);
        chk("fair_g3", grants[3], 3);
        chk("fair_g4", grants[4], 0);
        chk("fair_ready_rules", viol, 0);
        chk("fair_drained", 64'(busy), 0);

        // Backpressure: response held 10 cycles while req2/req3 wait
        rsp_ready = 1'b0;
        run_one(1, 1000, 10, lat);
        chk("bp_lat", lat, 33);
        chk("bp_q", 64'(rsp_quotient), 100);
        set_op(2, 77, 5);
        set_op(3, 50, 7);
        req_valid = 4'b1100;
        bp_bad = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_quotient !== 32'd100 ||
                rsp_remainder !== 32'd0 || rsp_div_by_zero !== 1'b0 ||
                req_ready !== 4'b0000 || busy !== 1'b1) bp_bad++;
        end
        chk("bp_stable", bp_bad, 0);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_released", 64'(rsp_valid), 0);
        chk("bp_next_grant", 64'(req_ready), 64'b0100);
        @(negedge clk);
        req_valid = '0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("bp2_lat", lat, 33);
        chk("bp2_id", 64'(rsp_id), 2);
        chk("bp2_q", 64'(rsp_quotient), 15);
        chk("bp2_r", 64'(rsp_remainder), 2);
        @(negedge clk);

        // Reset mid-RUN discards the result and restarts arbitration at requester 0
        set_op(1, 500, 3);
        req_valid = 4'b0010;
        #1;
        chk("mr_grant", 64'(req_ready), 64'b0010);
        @(negedge clk);
        req_valid = '0;
        repeat (10) @(negedge clk);
        chk("mr_busy_before", 64'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_rsp_valid", 64'(rsp_valid), 0);
        chk("mr_busy", 64'(busy), 0);
        chk("mr_fields", {rsp_quotient, rsp_remainder}, 0);
        chk("mr_id_dbz", {rsp_id, rsp_div_by_zero}, 0);
        set_op(0, 20, 4);
        set_op(3, 9, 2);
        req_valid = 4'b1001;
        #1;
        chk("mr_ready_in_reset", 64'(req_ready), 0);
        repeat (3) @(negedge clk);
        chk("mr_no_rsp", 64'(rsp_valid), 0);
        rst_n = 1'b1;
        #1;
        chk("mr_first_grant", 64'(req_ready), 64'b0001);
        @(negedge clk);
        req_valid = '0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("mr_after_id", 64'(rsp_id), 0);
        chk("mr_after_q", 64'(rsp_quotient), 5);
        chk("mr_after_r", 64'(rsp_remainder), 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
